keccak_round_sequencer: RTL and testbench

Top-level sequencer for the Keccak-f[1600] permutation datapath. It launches the five step units (theta, rho, pi, chi, iota) in order, one at a time, for every round, using a start-pulse / done-level handshake with each unit. It drives the round index that iota uses for its round-constant lookup, and it drives the ping-pong select of the two shared 64-line state buffers. A watchdog flags any step unit that hangs.

---
 rtl/keccak_pkg.sv | 38 +++
 rtl/keccak_round_sequencer_step_watchdog.sv | 42 ++++
 rtl/keccak_round_sequencer.sv | 140 ++++++++++++++
 tb/tb_keccak_round_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared encodings and constants for the Keccak-f[1600] round sequencer.
package keccak_pkg;

  typedef logic [2:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE    = 3'd0;
  localparam fsm_state_t ST_LAUNCH  = 3'd1;
  localparam fsm_state_t ST_WAIT    = 3'd2;
  localparam fsm_state_t ST_ADVANCE = 3'd3;
  localparam fsm_state_t ST_DONE    = 3'd4;
  localparam fsm_state_t ST_ERROR   = 3'd5;

  typedef logic [2:0] step_id_t;
  localparam step_id_t STEP_THETA = 3'd0;
  localparam step_id_t STEP_RHO   = 3'd1;
  localparam step_id_t STEP_PI    = 3'd2;
  localparam step_id_t STEP_CHI   = 3'd3;
  localparam step_id_t STEP_IOTA  = 3'd4;

  localparam int unsigned NUM_STEPS          = 5;
  localparam int unsigned DEFAULT_NUM_ROUNDS = 24;
  localparam int unsigned STATE_LINES        = 64;
  localparam int unsigned WDOG_W             = 16;

  // Launch vector for a step; unknown IDs launch nothing.
  function automatic logic [4:0] step_onehot(input step_id_t id);
    logic [4:0] vec;
    case (id)
      STEP_THETA: vec = 5'b00001;
      STEP_RHO:   vec = 5'b00010;
      STEP_PI:    vec = 5'b00100;
      STEP_CHI:   vec = 5'b01000;
      STEP_IOTA:  vec = 5'b10000;
      default:    vec = 5'b00000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/keccak_round_sequencer_step_watchdog.sv
// Saturating per-step cycle counter; expired flags that a step has waited TIMEOUT cycles.
module step_watchdog
  import keccak_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT   = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] CNT_MAX = {WDOG_W{1'b1}};

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/keccak_round_sequencer.sv
// Steps theta..iota once per round through a start/done handshake, driving the
// round index and the ping-pong buffer select; a watchdog traps hung step units.
module keccak_round_sequencer
  import keccak_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = DEFAULT_NUM_ROUNDS,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_done,
  output logic [4:0] step_start,
  output logic [2:0] step_sel,
  output logic [4:0] round_index,
  output logic       buf_sel,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  fsm_state_t state_q, state_d;
  step_id_t   step_sel_q, step_sel_d;
  logic [4:0] round_q, round_d;
  logic       buf_sel_q, buf_sel_d;
  logic [4:0] step_start_q, step_start_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       wd_clr, wd_en, wd_expired;

  step_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Next-state and counter updates.
  always_comb begin
    state_d    = state_q;
    step_sel_d = step_sel_q;
    round_d    = round_q;
    buf_sel_d  = buf_sel_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LAUNCH;
          step_sel_d = STEP_THETA;
          round_d    = 5'd0;
          buf_sel_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LAUNCH: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (step_done) begin
          state_d = ST_ADVANCE;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
        end else begin
          wd_en = 1'b1;
        end
      end
      ST_ADVANCE: begin
        buf_sel_d = ~buf_sel_q;
        if (step_sel_q < STEP_IOTA) begin
          step_sel_d = step_sel_q + 3'd1;
          state_d    = ST_LAUNCH;
        end else if (round_q < LAST_ROUND) begin
          step_sel_d = STEP_THETA;
          round_d    = round_q + 5'd1;
          state_d    = ST_LAUNCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    step_start_d = 5'b00000;
    if (state_d == ST_LAUNCH) begin
      step_start_d = step_onehot(step_sel_d);
    end else begin
      step_start_d = 5'b00000;
    end
    busy_d  = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) || (state_d == ST_ADVANCE);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_sel_q   <= STEP_THETA;
      round_q      <= 5'd0;
      buf_sel_q    <= 1'b0;
      step_start_q <= 5'b00000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_sel_q   <= step_sel_d;
      round_q      <= round_d;
      buf_sel_q    <= buf_sel_d;
      step_start_q <= step_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign step_start  = step_start_q;
  assign step_sel    = step_sel_q;
  assign round_index = round_q;
  assign buf_sel     = buf_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Bench for keccak_round_sequencer: a step-level timeline model builds per-cycle
// stimulus and expected outputs, then one loop drives the DUT and compares every cycle.
module tb_keccak_round_sequencer;

  localparam int NR    = 24;
  localparam int TO    = 1023;
  localparam int NSTEP = 5 * NR;
  localparam int MAXC  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       step_done = 1'b0;
  logic [4:0] step_start;
  logic [2:0] step_sel;
  logic [4:0] round_index;
  logic       buf_sel, busy, done, error;

  keccak_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_done   (step_done),
    .step_start  (step_start),
    .step_sel    (step_sel),
    .round_index (round_index),
    .buf_sel     (buf_sel),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  typedef struct packed {
    logic [4:0] ss;
    logic [2:0] sel;
    logic [4:0] rnd;
    logic       bf;
    logic       bz;
    logic       dn;
    logic       er;
  } outs_t;

  bit    t_start [MAXC];
  bit    t_done  [MAXC];
  bit    t_rst   [MAXC];
  bit    t_chk   [MAXC];
  outs_t t_exp   [MAXC];
  outs_t obs     [MAXC];
  int    tl = 0;
  int    w_plan [NSTEP];

  logic [2:0] h_sel;
  logic [4:0] h_rnd;
  logic       h_buf, h_err;

  int errors = 0;
  int checks = 0;
  int nom_s, nom_e, var_s, hang_s, tie_s, tie_e, ab_s;

  function automatic outs_t mk(input logic [4:0] ss, input logic [2:0] sel, input logic [4:0] rnd,
                               input logic bf, input logic bz, input logic dn, input logic er);
    outs_t o;
    o.ss = ss; o.sel = sel; o.rnd = rnd; o.bf = bf; o.bz = bz; o.dn = dn; o.er = er;
    return o;
  endfunction

  function automatic bit nz(input int one_in);
    return ($urandom_range(one_in - 1, 0) == 0);
  endfunction

  task automatic put(input bit s, input bit d, input bit r, input bit c, input outs_t e);
    if (tl < MAXC) begin
      t_start[tl] = s; t_done[tl] = d; t_rst[tl] = r; t_chk[tl] = c; t_exp[tl] = e;
      tl++;
    end
  endtask

  // Quiet cycles: outputs hold whatever the last run left (idle or error).
  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++)
      put(1'b0, noise && nz(3), 1'b0, 1'b1, mk(5'd0, h_sel, h_rnd, h_buf, 1'b0, 1'b0, h_err));
  endtask

  // One permutation: step k is launch + w_plan[k] waits + advance; done follows the last step.
  task automatic run(input int hang_k, input int abort_k, input bit tied, input bit noise,
                     output int start_cyc);
    logic [2:0] s3;
    logic [4:0] r5;
    logic       bf;
    start_cyc = tl;
    put(1'b1, tied || (noise && nz(2)), 1'b0, 1'b1, mk(5'd0, h_sel, h_rnd, h_buf, 1'b0, 1'b0, h_err));
    for (int k = 0; k < NSTEP; k++) begin
      s3 = 3'(k % 5);
      r5 = 5'(k / 5);
      bf = ((k % 2) == 1);
      put(noise && nz(8), tied || (noise && nz(2)), 1'b0, 1'b1,
          mk(5'b00001 << s3, s3, r5, bf, 1'b1, 1'b0, 1'b0));
      if (k == hang_k) begin
        for (int i = 0; i <= TO; i++)
          put(noise && nz(8), 1'b0, 1'b0, 1'b1, mk(5'd0, s3, r5, bf, 1'b1, 1'b0, 1'b0));
        h_sel = s3; h_rnd = r5; h_buf = bf; h_err = 1'b1;
        return;
      end
      for (int i = 1; i <= w_plan[k]; i++) begin
        if (k == abort_k && i == 2) begin
          put(1'b0, 1'b0, 1'b1, 1'b1, mk(5'd0, s3, r5, bf, 1'b1, 1'b0, 1'b0));
          h_sel = 3'd0; h_rnd = 5'd0; h_buf = 1'b0; h_err = 1'b0;
          return;
        end
        put(noise && nz(8), (i == w_plan[k]), 1'b0, 1'b1, mk(5'd0, s3, r5, bf, 1'b1, 1'b0, 1'b0));
      end
      put(noise && nz(8), tied || (noise && nz(2)), 1'b0, 1'b1,
          mk(5'd0, s3, r5, bf, 1'b1, 1'b0, 1'b0));
    end
    h_sel = 3'd4; h_rnd = 5'(NR - 1); h_buf = ((NSTEP % 2) == 1); h_err = 1'b0;
    put(noise && nz(2), tied || (noise && nz(2)), 1'b0, 1'b1,
        mk(5'd0, h_sel, h_rnd, h_buf, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic pin(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic plan_random(input int lo, input int hi);
    for (int k = 0; k < NSTEP; k++) w_plan[k] = $urandom_range(hi, lo);
  endtask

  initial begin
    int dcyc, pulses, e_cyc, l_cyc, cnt;
    h_sel = 3'd0; h_rnd = 5'd0; h_buf = 1'b0; h_err = 1'b0;

    put(1'b0, 1'b0, 1'b1, 1'b0, mk(5'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    put(1'b0, 1'b0, 1'b1, 1'b1, mk(5'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(4, 1'b1);
    plan_random(1, 1);
    run(-1, -1, 1'b1, 1'b0, nom_s);
    nom_e = tl;
    idle(5, 1'b1);
    plan_random(1, 20);
    run(-1, -1, 1'b0, 1'b1, var_s);
    idle(5, 1'b1);
    plan_random(1, 5);
    run(18, -1, 1'b0, 1'b1, hang_s);
    idle(8, 1'b1);
    plan_random(1, 3);
    w_plan[7] = TO + 1;
    run(-1, -1, 1'b0, 1'b1, tie_s);
    tie_e = tl;
    idle(6, 1'b1);
    plan_random(1, 3);
    w_plan[52] = 4;
    run(-1, 52, 1'b0, 1'b1, ab_s);
    idle(6, 1'b1);

    for (int c = 0; c < tl; c++) begin
      @(posedge clk);
      #1;
      rst       = t_rst[c];
      start     = t_start[c];
      step_done = t_done[c];
      @(negedge clk);
      obs[c] = mk(step_start, step_sel, round_index, buf_sel, busy, done, error);
      if (t_chk[c]) begin
        checks++;
        if (obs[c] !== t_exp[c]) begin
          errors++;
          $display("FAIL cycle%0d outputs: got ss=%b sel=%0d rnd=%0d buf=%b busy=%b done=%b err=%b, expected ss=%b sel=%0d rnd=%0d buf=%b busy=%b done=%b err=%b",
                   c, obs[c].ss, obs[c].sel, obs[c].rnd, obs[c].bf, obs[c].bz, obs[c].dn, obs[c].er,
                   t_exp[c].ss, t_exp[c].sel, t_exp[c].rnd, t_exp[c].bf, t_exp[c].bz, t_exp[c].dn, t_exp[c].er);
        end
      end
    end

    // Literal expectations on the observed DUT behaviour.
    dcyc = -1;
    for (int c = nom_s; c < nom_e; c++) if (dcyc < 0 && obs[c].dn) dcyc = c;
    pin("nominal_done_latency", dcyc - nom_s, 361);
    pulses = 0;
    for (int c = nom_s; c < nom_e; c++) pulses += $countones(obs[c].ss);
    pin("nominal_pulse_count", pulses, 120);
    pin("nominal_final_buf", (dcyc >= 0) ? int'(obs[dcyc].bf) : -1, 0);
    pin("nominal_final_round", (dcyc >= 0) ? int'(obs[dcyc].rnd) : -1, 23);

    e_cyc = -1;
    for (int c = hang_s; c < tie_s; c++) if (e_cyc < 0 && obs[c].er) e_cyc = c;
    l_cyc = -1;
    for (int c = hang_s; c < e_cyc; c++) if (obs[c].ss == 5'b01000) l_cyc = c;
    pin("hang_timeout_cycles", e_cyc - l_cyc, 1025);
    pin("hang_busy_low", (e_cyc >= 0) ? int'(obs[e_cyc].bz) : -1, 0);
    pin("hang_round_hold", (e_cyc >= 0) ? int'(obs[e_cyc].rnd) : -1, 3);
    pin("hang_step_hold", (e_cyc >= 0) ? int'(obs[e_cyc].sel) : -1, 3);

    cnt = 0;
    for (int c = tie_s + 1; c < tie_e; c++) cnt += int'(obs[c].er);
    pin("tie_no_error", cnt, 0);
    cnt = 0;
    for (int c = ab_s; c < tl; c++) cnt += int'(obs[c].dn);
    pin("abort_no_done", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
